// File: rtl/load_store_unit_pkg.sv
// Shared types, width codes and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } lsu_cause_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Unsigned widths only exist for loads; stores with BU/HU are rejected.
    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            LSU_B, LSU_H, LSU_W: bad = 1'b0;
            LSU_BU, LSU_HU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            LSU_H, LSU_HU: mis = off[0];
            LSU_W:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            LSU_B, LSU_BU: be = 4'b0001 << off;
            LSU_H, LSU_HU: be = 4'b0011 << off;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating across lanes lets the byte enables alone select the target bytes.
    function automatic logic [31:0] lsu_store_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        case (f3)
            LSU_B, LSU_BU: d = {4{wdata[7:0]}};
            LSU_H, LSU_HU: d = {2{wdata[15:0]}};
            default:       d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the addressed bytes of a read word down to bit 0 and extends them.
module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import lsu_pkg::*;

    logic [31:0] shifted;

    // Lane select followed by sign/zero extension for the requested width.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            LSU_B:   data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_H:   data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_W:   data = shifted;
            LSU_BU:  data = {24'd0, shifted[7:0]};
            LSU_HU:  data = {16'd0, shifted[15:0]};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: decodes a load/store, runs one req/ack bus
// transaction, stalls the core meanwhile and reports the result or a fault.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for valid_i; decode faults go straight to ST_DONE
// ST_BUSY | mem_req_o held, waiting for mem_ack_i or the timeout
// ST_DONE | done_o pulse, result/fault presented, core advances
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    import lsu_pkg::*;

    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [7:0]  cnt_q;
    logic        dec_illegal, dec_misalign;
    logic        tmo_hit;
    logic [31:0] load_data;

    assign dec_illegal  = lsu_illegal(we_i, funct3_i);
    assign dec_misalign = lsu_misaligned(funct3_i, addr_i[1:0]);
    // Down-counter loaded with TIMEOUT-1; terminal count means the last allowed wait cycle.
    assign tmo_hit      = (cnt_q == 8'd0);
    assign stall_o      = ((state_q == ST_IDLE) && valid_i) || (state_q == ST_BUSY);

    lsu_load_align u_align (
        .rdata  (mem_rdata_i),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; an ack on the terminal-count cycle still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (valid_i) state_d = (dec_illegal || dec_misalign) ? ST_DONE : ST_BUSY;
            ST_BUSY: if (mem_ack_i || tmo_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered bus outputs, result and fault reporting, timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_o        <= 1'b0;
            rdata_o       <= 32'd0;
            fault_o       <= 1'b0;
            fault_cause_o <= CAUSE_NONE;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= 4'd0;
            mem_addr_o    <= 32'd0;
            mem_wdata_o   <= 32'd0;
            off_q         <= 2'd0;
            f3_q          <= 3'd0;
            cnt_q         <= 8'd0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (dec_illegal) begin
                            done_o        <= 1'b1;
                            fault_o       <= 1'b1;
                            fault_cause_o <= CAUSE_ILLEGAL;
                            rdata_o       <= 32'd0;
                        end else if (dec_misalign) begin
                            done_o        <= 1'b1;
                            fault_o       <= 1'b1;
                            fault_cause_o <= CAUSE_MISALIGN;
                            rdata_o       <= 32'd0;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= we_i;
                            mem_be_o    <= lsu_byte_en(funct3_i, addr_i[1:0]);
                            mem_addr_o  <= {addr_i[31:2], 2'b00};
                            mem_wdata_o <= lsu_store_data(funct3_i, wdata_i);
                            off_q       <= addr_i[1:0];
                            f3_q        <= funct3_i;
                            cnt_q       <= 8'(TIMEOUT - 1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i || tmo_hit) begin
                        done_o        <= 1'b1;
                        fault_o       <= !mem_ack_i;
                        fault_cause_o <= mem_ack_i ? CAUSE_NONE : CAUSE_TIMEOUT;
                        rdata_o       <= (mem_ack_i && !mem_we_o) ? load_data : 32'd0;
                        mem_req_o     <= 1'b0;
                        mem_we_o      <= 1'b0;
                        mem_be_o      <= 4'd0;
                        mem_addr_o    <= 32'd0;
                        mem_wdata_o   <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, hand-written
// timeout/reset sequences and randomized accesses against a byte-level model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, fault_o;
    logic [31:0] rdata_o;
    logic [1:0]  fault_cause_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;   // BUSY cycle (1-based) carrying the ack; 0 = never
        logic [31:0] rd;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        int          lat;      // cycle of done_o relative to the valid_i cycle
    } vec_t;

    vec_t tbl [11];

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t dv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ack_at, input logic [31:0] rd,
                                input logic [1:0] cause, input logic [31:0] rdata, input logic [3:0] be,
                                input logic [31:0] maddr, input logic [31:0] mwdata, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.ack_at = ack_at; v.rd = rd;
        v.cause = cause; v.rdata = rdata; v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.lat = lat;
        return v;
    endfunction

    // Reference model: byte counts, modular offsets and masks, no state machine.
    function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int ack_at, input logic [31:0] rd);
        vec_t v;
        int nb, off;
        logic [31:0] mask, val;
        v = dv(we, f3, addr, wdata, ack_at, rd, 2'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1);
        off = int'(addr % 4);
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2])) begin
            v.cause = 2'd3;
        end else if ((off % nb) != 0) begin
            v.cause = 2'd1;
        end else begin
            v.be     = 4'(((1 << nb) - 1) << off);
            v.maddr  = addr - 32'(off);
            v.mwdata = (nb == 1) ? wdata[7:0] * 32'h0101_0101 :
                       (nb == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
            if (ack_at >= 1 && ack_at <= TMO) begin
                v.lat = ack_at + 1;
                if (!we) begin
                    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
                    val  = (rd >> (8 * off)) & mask;
                    if (!f3[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
                    v.rdata = val;
                end
            end else begin
                v.cause = 2'd2;
                v.lat   = TMO + 1;
            end
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk); #1;
        valid_i = 1'b1; we_i = v.we; funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk({tag, " c0 stall/req/done"}, 64'({stall_o, mem_req_o, done_o}), 64'(3'b100));
        for (int c = 1; c <= v.lat; c++) begin
            @(posedge clk); #1;
            if (c == v.ack_at) begin mem_ack_i = 1'b1; mem_rdata_i = v.rd; end
            else begin mem_ack_i = 1'b0; mem_rdata_i = $urandom; end
            @(negedge clk);
            if (c < v.lat) begin
                chk({tag, " busy ctrl"}, 64'({stall_o, done_o, mem_req_o, mem_we_o, mem_be_o}),
                    64'({1'b1, 1'b0, 1'b1, v.we, v.be}));
                chk({tag, " busy addr"}, 64'(mem_addr_o), 64'(v.maddr));
                if (v.we) chk({tag, " busy wdata"}, 64'(mem_wdata_o), 64'(v.mwdata));
            end else begin
                chk({tag, " done ctrl"}, 64'({done_o, stall_o, mem_req_o, fault_o, fault_cause_o}),
                    64'({1'b1, 1'b0, 1'b0, (v.cause != 2'd0), v.cause}));
                if (v.cause == 2'd0 || v.cause == 2'd2)
                    chk({tag, " rdata"}, 64'(rdata_o), 64'(v.rdata));
            end
        end
        @(posedge clk); #1;
        valid_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        chk({tag, " idle after done"}, 64'({done_o, mem_req_o, stall_o}), 64'(0));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'd0;
        addr_i = 32'd0; wdata_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;

        //            we    f3      addr          wdata         ack rd            cause rdata         be       maddr         mwdata        lat
        tbl[0]  = dv(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0,        2'd0, 32'h0,        4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 2);
        tbl[1]  = dv(1'b0, 3'b000, 32'h0000_0103, 32'h0,         3, 32'h80FF_0000, 2'd0, 32'hFFFF_FF80, 4'b1000, 32'h0000_0100, 32'h0,        4);
        tbl[2]  = dv(1'b0, 3'b100, 32'h0000_0103, 32'h0,         3, 32'h80FF_0000, 2'd0, 32'h0000_0080, 4'b1000, 32'h0000_0100, 32'h0,        4);
        tbl[3]  = dv(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h0,        2'd0, 32'h0,        4'b1100, 32'h0000_0100, 32'hABCD_ABCD, 2);
        tbl[4]  = dv(1'b0, 3'b010, 32'h0000_0101, 32'h0,         1, 32'h0,        2'd1, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        tbl[5]  = dv(1'b0, 3'b011, 32'h0000_0100, 32'h0,         1, 32'h0,        2'd3, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        tbl[6]  = dv(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0011, 1, 32'h0,        2'd3, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        tbl[7]  = dv(1'b0, 3'b001, 32'h0000_0002, 32'h0,         2, 32'h8001_0000, 2'd0, 32'hFFFF_8001, 4'b1100, 32'h0000_0000, 32'h0,        3);
        tbl[8]  = dv(1'b1, 3'b000, 32'h0000_0001, 32'h0000_0055, 4, 32'h0,        2'd0, 32'h0,        4'b0010, 32'h0000_0000, 32'h5555_5555, 5);
        tbl[9]  = dv(1'b0, 3'b101, 32'h0000_0003, 32'h0,         1, 32'h0,        2'd1, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        tbl[10] = dv(1'b1, 3'b101, 32'h0000_0001, 32'h0,         1, 32'h0,        2'd3, 32'h0,        4'b0000, 32'h0,        32'h0,        1);

        #3;
        chk("reset ctrl", 64'({stall_o, done_o, fault_o, fault_cause_o, mem_req_o, mem_we_o, mem_be_o}), 64'(0));
        chk("reset rdata", 64'(rdata_o), 64'(0));
        chk("reset addr/wdata", {mem_addr_o, mem_wdata_o}, 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Timeout, then a late ack in IDLE that must be ignored, then a normal LW.
        run_vec(dv(1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 32'h0, 2'd2, 32'h0, 4'b1111, 32'h0000_0200, 32'h0, TMO + 1), "timeout");
        @(posedge clk); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("late ack ignored", 64'({done_o, mem_req_o, stall_o}), 64'(0));
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("late ack no done", 64'({done_o, mem_req_o}), 64'(0));
        run_vec(dv(1'b0, 3'b010, 32'h0000_0204, 32'h0, 2, 32'h1122_3344, 2'd0, 32'h1122_3344, 4'b1111, 32'h0000_0204, 32'h0, 3), "lw after timeout");

        // Asynchronous reset in the middle of BUSY.
        @(posedge clk); #1;
        valid_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0300; wdata_i = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-reset busy req", 64'(mem_req_o), 64'(1));
        #2;
        rst_n = 1'b0; valid_i = 1'b0;
        #1;
        chk("async reset ctrl", 64'({stall_o, done_o, fault_o, fault_cause_o, mem_req_o, mem_we_o, mem_be_o}), 64'(0));
        chk("async reset addr/wdata", {mem_addr_o, mem_wdata_o}, 64'(0));
        chk("async reset rdata", 64'(rdata_o), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no done after reset", 64'({done_o, mem_req_o}), 64'(0));
        end
        run_vec(dv(1'b0, 3'b101, 32'h0000_0002, 32'h0, 1, 32'hF00D_0000, 2'd0, 32'h0000_F00D, 4'b1100, 32'h0000_0000, 32'h0, 2), "lhu after reset");

        // Randomized accesses against the model.
        for (int i = 0; i < 200; i++) begin
            v = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, int'($urandom_range(1, TMO + 2)), $urandom);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
